// File: rtl/tiny_rv_pkg.sv
// Shared encodings, FSM state type and immediate decoders for the tiny RV32I-subset core.
package tiny_rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    function automatic logic [31:0] imm_i(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:25], ir[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ir);
        return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/tiny_rv_regfile.sv
// Register file: two combinational read ports, one write port, x0 hard-wired to zero.
module tiny_rv_regfile #(
    parameter int NREGS = 16,
    parameter int XLEN  = 32,
    localparam int RAW  = $clog2(NREGS)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [RAW-1:0]  raddr1,
    input  logic [RAW-1:0]  raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [RAW-1:0]  waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we && waddr != '0) regs_d[waddr] = wdata;
    end

    always_ff @(posedge CLK) begin
        if (RST) regs_q <= '{default: '0};
        else     regs_q <= regs_d;
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/tiny_rv_core.sv
// Multi-cycle RV32I-subset core: FETCH/EXEC/MEM/HALT, gated by step_en, LEDs mirror last write-back.
module tiny_rv_core
    import tiny_rv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREGS      = 16,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 256
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          step_en,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_wdata,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc,
    output logic                          halted,
    output logic                          led_red,
    output logic                          led_green,
    output logic                          led_blue
);

    localparam int PCW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);
    localparam int RAW = $clog2(NREGS);

    state_t          state_q, state_d;
    logic [PCW-1:0]  pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] last_wb_q, last_wb_d;
    logic [XLEN-1:0] ld_data_q, ld_data_d;
    logic [2:0]      led_q;

    logic [31:0]     imem_mem [IMEM_DEPTH];
    logic [XLEN-1:0] dmem_mem [DMEM_DEPTH];

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [RAW-1:0]  rd, rs1, rs2;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_i_x, imm_s_x, op_b, alu_res, ea, rf_wdata;
    logic [DAW-1:0]  daddr;
    logic [PCW-1:0]  br_off;
    logic            alu_ok, wb_en, rf_we, dmem_we;

    assign opcode  = ir_q[6:0];
    assign funct3  = ir_q[14:12];
    assign funct7  = ir_q[31:25];
    assign rd      = ir_q[7 +: RAW];
    assign rs1     = ir_q[15 +: RAW];
    assign rs2     = ir_q[20 +: RAW];
    assign imm_i_x = XLEN'($signed(imm_i(ir_q)));
    assign imm_s_x = XLEN'($signed(imm_s(ir_q)));
    // Byte offsets become word offsets; truncation gives the modulo wrap for free.
    assign br_off  = PCW'(imm_b(ir_q) >> 2);
    assign ea      = rs1_val + ((opcode == OP_STORE) ? imm_s_x : imm_i_x);
    assign daddr   = DAW'(ea >> 2);

    tiny_rv_regfile #(.NREGS(NREGS), .XLEN(XLEN)) u_rf (
        .CLK    (CLK),
        .RST    (RST),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (rf_wdata)
    );

    always_comb begin
        op_b    = (opcode == OP_R) ? rs2_val : imm_i_x;
        alu_ok  = 1'b1;
        alu_res = '0;
        case (funct3)
            F3_ADD: alu_res = (opcode == OP_R && funct7 == F7_SUB) ? rs1_val - op_b : rs1_val + op_b;
            F3_SLT: begin
                alu_res = XLEN'($signed(rs1_val) < $signed(op_b));
                alu_ok  = (opcode == OP_R);
            end
            F3_XOR: alu_res = rs1_val ^ op_b;
            F3_OR:  alu_res = rs1_val | op_b;
            F3_AND: alu_res = rs1_val & op_b;
            default: alu_ok = 1'b0;
        endcase
        if (opcode == OP_R && funct7 != F7_BASE && !(funct7 == F7_SUB && funct3 == F3_ADD))
            alu_ok = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        last_wb_d = last_wb_q;
        ld_data_d = ld_data_q;
        wb_en     = 1'b0;
        rf_wdata  = alu_res;
        dmem_we   = 1'b0;
        if (step_en) begin
            case (state_q)
                S_FETCH: begin
                    ir_d    = imem_mem[pc_q];
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    state_d = S_FETCH;
                    pc_d    = pc_q + PCW'(1);
                    case (opcode)
                        OP_R, OP_I: begin
                            if (alu_ok) wb_en = 1'b1;
                            else        state_d = S_HALT;
                        end
                        OP_LOAD: begin
                            if (funct3 == F3_LW) begin
                                ld_data_d = dmem_mem[daddr];
                                state_d   = S_MEM;
                            end else begin
                                state_d = S_HALT;
                            end
                        end
                        OP_STORE: begin
                            if (funct3 == F3_SW) dmem_we = 1'b1;
                            else                 state_d = S_HALT;
                        end
                        OP_BRANCH: begin
                            if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                                if ((rs1_val == rs2_val) == (funct3 == F3_BEQ)) pc_d = pc_q + br_off;
                            end else begin
                                state_d = S_HALT;
                            end
                        end
                        default: state_d = S_HALT;
                    endcase
                    // LW advances pc when its MEM phase retires; a halt freezes it.
                    if (state_d == S_HALT || state_d == S_MEM) pc_d = pc_q;
                end
                S_MEM: begin
                    wb_en    = 1'b1;
                    rf_wdata = ld_data_q;
                    pc_d     = pc_q + PCW'(1);
                    state_d  = S_FETCH;
                end
                default: ;
            endcase
        end
        rf_we = wb_en && (rd != '0);
        if (rf_we) last_wb_d = rf_wdata;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            last_wb_q <= '0;
            ld_data_q <= '0;
            led_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            last_wb_q <= last_wb_d;
            ld_data_q <= ld_data_d;
            led_q     <= last_wb_q[2:0];
        end
    end

    // Memories are never reset; IMEM loading works in every state.
    always_ff @(posedge CLK) begin
        if (imem_we)          imem_mem[imem_addr] <= imem_wdata;
        if (dmem_we && !RST)  dmem_mem[daddr]     <= rs2_val;
    end

    assign pc        = pc_q;
    assign halted    = (state_q == S_HALT);
    assign led_red   = led_q[0];
    assign led_green = led_q[1];
    assign led_blue  = led_q[2];

endmodule

// File: doc/tiny_rv_core.md
# tiny_rv_core

Parametrised multi-cycle RV32I-subset core, next generation of the tiny 8-bit CPU board demo. Fetches from a loadable instruction memory, executes R/I-type ALU ops, LW/SW against a word-addressed data memory, and BEQ/BNE branches. Runs at a rate gated by `step_en` and drives the three board LEDs from the last register write-back. Illegal or ECALL instructions halt the core.

## Interface
- `XLEN`, 32: datapath width.
- `NREGS`, 16: architectural registers (x0..x(NREGS-1)); must be a power of 2, at most 32.
- `IMEM_DEPTH`, 16: instruction words; power of 2.
- `DMEM_DEPTH`, 256: data words; power of 2.

- `CLK` in 1: system clock.
- `RST` in 1: synchronous, active-high reset.
- `step_en` in 1: FSM advances only on cycles where this is high.
- `imem_we` in 1: instruction memory write strobe.
- `imem_addr` in log2(IMEM_DEPTH): write address.
- `imem_wdata` in 32: instruction word.
- `pc` out log2(IMEM_DEPTH): current PC, as a word index.
- `halted` out 1: core stopped.
- `led_red`, `led_green`, `led_blue` out 1: bits 0, 1 and 2 of the last write-back value.

## Operation
- FSM states: FETCH, EXEC, MEM, HALT. Reset enters FETCH.
- FETCH, with `step_en`: IR <= IMEM[pc]; next state EXEC.
- EXEC, with `step_en`: decode IR and act by opcode.
  - 0110011, R-type: funct3/funct7 select ADD, SUB (funct7=0100000), AND, OR, XOR, SLT (signed).
  - 0010011, I-type: ADDI, ANDI, ORI, XORI with a sign-extended 12-bit immediate.
  - 0000011, funct3=010, LW: latch the address; next state MEM.
  - 0100011, funct3=010, SW: write DMEM.
  - 1100011, BEQ/BNE: if taken, pc <= pc + (imm_b >> 2).
  - Every other opcode or funct3, including ECALL: next state HALT.
  - pc <= pc + 1 when not taken. All non-LW, non-halt paths return to FETCH.
- MEM, with `step_en`: rd <= DMEM[addr]; pc <= pc + 1; next state FETCH.
- HALT: absorbing until `RST`. `step_en` is ignored and `imem_we` is still accepted.
- Write-back rules:
  - rd == 0 is discarded; x0 always reads 0.
  - rd or rs index bits above log2(NREGS) are ignored (truncated).
  - Each write-back to rd != 0 updates `last_wb` with the written value. SW, branches and x0 writes do not update it.
- Arithmetic:
  - Results are XLEN bits with wrap-around, no flags.
  - Data address = (rs1 + imm) >> 2, modulo DMEM_DEPTH.
  - pc arithmetic is modulo IMEM_DEPTH, so the branch target and pc+1 both wrap.
- Reset values: pc=0, IR=0, all registers 0, `last_wb`=0, `halted`=0, LEDs 0, state FETCH. DMEM and IMEM contents are not reset.
- `RST` in any state, including mid-LW in MEM, aborts the instruction with no register write.

## Timing
- With `step_en` held high:
  - ALU, SW and branch instructions take 2 cycles.
  - LW takes 3 cycles.
- `step_en` low freezes all state. IMEM writes are still accepted.
- Register, DMEM and `last_wb` updates are visible the cycle after the EXEC or MEM edge.
- LEDs are registered from `last_wb`: 1-cycle delay after write-back.
- `halted` rises the cycle after the EXEC edge that decodes an illegal instruction.
- IMEM write and FETCH of the same address on the same edge: fetch returns the old word (read-before-write).
- DMEM is synchronous read and write, one port. SW followed by LW to the same address returns the stored value.

## Structure
- Package `tiny_rv_pkg`:
  - opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH.
  - funct3/funct7 constants.
  - state enum.
  - immediate-extraction functions imm_i, imm_s, imm_b.
- Sub-module `tiny_rv_regfile` (parameters NREGS, XLEN): 2 async read ports, 1 sync write port, x0 write suppression, synchronous clear on `RST`.
- IMEM and DMEM are inferred arrays inside the core.

## Test plan
- Load ADDI x1,x0,5; ADDI x2,x0,3; ADD x3,x1,x2; ORI x5,x3,1 and step 8 cycles -> x3=8, x5=9; final LEDs red=1, green=0, blue=0.
- SUB x4,x1,x2 with x1=3, x2=5 -> x4=0xFFFFFFFE. SLT x6,x4,x0 -> x6=1.
- ADDI x1,x0,42; SW x1,8(x0); LW x7,8(x0) -> DMEM[2]=42, x7=42; the LW takes 3 cycles.
- BEQ x0,x0,-4 at pc=3 -> pc=2. BNE x0,x0,+8 -> pc advances by 1. A branch from pc=15 with offset +4 wraps to pc=0.
- ADDI x0,x0,7 -> x0 stays 0 and the LEDs do not change. Word 0x00000073 -> `halted`=1, pc frozen, `step_en` has no effect.
- Assert `RST` during MEM of an LW -> the destination register is not written; pc=0, LEDs 0, `halted`=0 the next cycle.
